dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_LOG2, default 10: log2 of DRAM word count (1024 x 32-bit words).
REQ-002 Parameter IO_BIT, default 20: word-address bit that selects the MMIO region when set.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 read_ce  input  1  read request, sampled every cycle.
REQ-006 read_addr  input  32  word address of the read; bits [1:0] are not byte offsets.
REQ-007 write_ce  input  1  write request, sampled every cycle.
REQ-008 write_addr  input  32  word address of the write.
REQ-009 wdata  input  32  write data, already lane-formatted by the initiator.
REQ-010 rdata  output  32  read data returned to the initiator.
REQ-011 busy  output  1  high while a DRAM read is outstanding (state RD_WAIT).
REQ-012 sw_in  input  16  external switch inputs.
REQ-013 led_out  output  16  LED register.

Function
REQ-014 Region decode: addr[IO_BIT]==0 selects DRAM; addr[IO_BIT]==1 selects MMIO, offset addr[3:0].
REQ-015 DRAM index is addr[DEPTH_LOG2-1:0]; higher bits are ignored, so index wraps modulo 2^DEPTH_LOG2.
REQ-016 DRAM write commits at the rising edge where write_ce==1; no write occurs when write_ce==0.
REQ-017 DRAM read latency is one cycle: with read_ce sampled high at edge N, rdata holds the word from edge N onward until the next DRAM read is captured.
REQ-018 Same-edge read and write to the same DRAM index: write-first, so rdata returns wdata.
REQ-019 MMIO reads are combinational: while read_ce==1 and the read address is MMIO, rdata shows the MMIO value in the same cycle.
REQ-020 MMIO map: 0x0 LED (RW, low 16 bits); 0x1 switches (RO, zero-extended sw_in); 0x2 timer (RO, under the macro); 0x3 scratch (RW, 32 bits); all other offsets read 0 and ignore writes.
REQ-021 sw_in passes through a two-flop synchronizer; the 0x1 read returns the second-stage value.
REQ-022 Otherwise rdata holds the last registered DRAM read value.
REQ-023 FSM states: IDLE and RD_WAIT; IDLE->RD_WAIT on a DRAM read; RD_WAIT->RD_WAIT on a back-to-back DRAM read; RD_WAIT->IDLE otherwise.
REQ-024 Simultaneous read and write to different regions or indices are both serviced in the same cycle.

Reset
REQ-025 On rst: rdata=0, led_out=0, scratch=0, timer=0, synchronizer flops=0, state=IDLE, busy=0.
REQ-026 DRAM array contents are not reset.
REQ-027 Reset during RD_WAIT drops the pending read; rdata stays 0 until a new read is captured.

Configuration
REQ-028 Macro DMEM_MMIO_TIMER_EN, when defined: a 32-bit free-running timer increments by 1 each cycle, wraps from 0xFFFFFFFF to 0, and is readable at offset 0x2.
REQ-029 Without DMEM_MMIO_TIMER_EN: no timer logic exists, and offset 0x2 reads 0.

Structure
REQ-030 A shared package dmem_pkg holds the region-decode constants, the MMIO offset constants and the FSM state typedef.
REQ-031 Sub-module dmem_sram is a single-port-write / single-port-read synchronous RAM with write-first forwarding; the top level holds decode, MMIO and the FSM.

Verification
REQ-032 Write 0xDEADBEEF to 0x00000005, then read 0x00000005 -> rdata=0xDEADBEEF one cycle after the read edge; busy=1 for exactly that cycle.
REQ-033 Same-edge write 0x12345678 and read at 0x00000007 -> rdata=0x12345678 after the edge.
REQ-034 Write 0xAAAA5555 to 0x00000405 (DEPTH_LOG2=10), then read 0x00000005 -> rdata=0xAAAA5555 (wrap).
REQ-035 Write 0x0001BEEF to 0x00100000 -> led_out=0xBEEF; sw_in=0x00F0 held 3 cycles, then read 0x00100001 -> rdata=0x000000F0 in the same cycle.
REQ-036 Read 0x0010000F -> rdata=0; with DMEM_MMIO_TIMER_EN, two reads of 0x00100002 taken 5 cycles apart differ by 5.
REQ-037 Assert rst mid-RD_WAIT -> rdata=0, busy=0 and led_out=0 immediately; state returns to IDLE.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: region decode, MMIO offsets,
// and the read-tracking FSM state type.
package dmem_pkg;

    localparam int DEPTH_LOG2_DEFAULT = 10;
    localparam int IO_BIT_DEFAULT     = 20;

    localparam logic REGION_DRAM = 1'b0;
    localparam logic REGION_MMIO = 1'b1;

    localparam int         MMIO_OFF_W   = 4;
    localparam logic [3:0] MMIO_LED     = 4'h0;
    localparam logic [3:0] MMIO_SW      = 4'h1;
    localparam logic [3:0] MMIO_TIMER   = 4'h2;
    localparam logic [3:0] MMIO_SCRATCH = 4'h3;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } dmem_state_t;

    function automatic logic is_mmio(input logic [31:0] addr, input int io_bit);
        return addr[io_bit] == REGION_MMIO;
    endfunction

endpackage

// File: rtl/dmem_sram.sv
// Synchronous RAM, one write port and one registered read port. A read and a
// write to the same index on the same edge return the new data.
module dmem_sram #(
    parameter int DEPTH_LOG2 = 10,
    parameter int WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem [0:(1 << DEPTH_LOG2)-1];

    // Array contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: DRAM/MMIO decode, MMIO registers and read-tracking FSM.
// Define DMEM_MMIO_TIMER_EN to add a free-running 32-bit timer at MMIO offset 0x2.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEFAULT,
    parameter int IO_BIT     = IO_BIT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read_ce,
    input  logic [31:0] read_addr,
    input  logic        write_ce,
    input  logic [31:0] write_addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        busy,
    input  logic [15:0] sw_in,
    output logic [15:0] led_out
);

    logic                  rd_mmio;
    logic                  wr_mmio;
    logic                  dram_rd;
    logic                  dram_wr;
    logic [MMIO_OFF_W-1:0] rd_off;
    logic [MMIO_OFF_W-1:0] wr_off;
    logic [31:0]           dram_rdata;
    logic [31:0]           mmio_rdata;
    logic [31:0]           timer_val;
    logic [15:0]           sw_s1;
    logic [15:0]           sw_s2;
    logic [15:0]           led_q;
    logic [31:0]           scratch_q;
    dmem_state_t           state_q;
    dmem_state_t           state_d;
    logic                  unused_addr_bits;

    assign rd_mmio = read_ce && is_mmio(read_addr, IO_BIT);
    assign wr_mmio = write_ce && is_mmio(write_addr, IO_BIT);
    assign dram_rd = read_ce && (read_addr[IO_BIT] == REGION_DRAM);
    assign dram_wr = write_ce && (write_addr[IO_BIT] == REGION_DRAM);
    assign rd_off  = read_addr[MMIO_OFF_W-1:0];
    assign wr_off  = write_addr[MMIO_OFF_W-1:0];

    // Upper address bits outside the index and region bit are don't-care.
    assign unused_addr_bits = ^{read_addr, write_addr};

    dmem_sram #(
        .DEPTH_LOG2(DEPTH_LOG2),
        .WIDTH     (32)
    ) u_sram (
        .clk  (clk),
        .rst  (rst),
        .we   (dram_wr),
        .waddr(write_addr[DEPTH_LOG2-1:0]),
        .wdata(wdata),
        .re   (dram_rd),
        .raddr(read_addr[DEPTH_LOG2-1:0]),
        .rdata(dram_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_s1 <= '0;
            sw_s2 <= '0;
        end else begin
            sw_s1 <= sw_in;
            sw_s2 <= sw_s1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_q     <= '0;
            scratch_q <= '0;
        end else if (wr_mmio) begin
            case (wr_off)
                MMIO_LED:     led_q     <= wdata[15:0];
                MMIO_SCRATCH: scratch_q <= wdata;
                default:      ;
            endcase
        end
    end

`ifdef DMEM_MMIO_TIMER_EN
    logic [31:0] timer_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_q + 32'd1;
        end
    end

    assign timer_val = timer_q;
`else
    assign timer_val = '0;
`endif

    always_comb begin
        mmio_rdata = '0;
        case (rd_off)
            MMIO_LED:     mmio_rdata = {16'h0, led_q};
            MMIO_SW:      mmio_rdata = {16'h0, sw_s2};
            MMIO_TIMER:   mmio_rdata = timer_val;
            MMIO_SCRATCH: mmio_rdata = scratch_q;
            default:      mmio_rdata = '0;
        endcase
    end

    // MMIO reads bypass the registered DRAM word for the current cycle only.
    assign rdata   = rd_mmio ? mmio_rdata : dram_rdata;
    assign led_out = led_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = dram_rd ? RD_WAIT : IDLE;
            RD_WAIT: state_d = dram_rd ? RD_WAIT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == RD_WAIT);

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized and directed bench for dmem_responder with a reference model and
// an expected-response queue drained by a negedge monitor.
module tb_dmem_responder;

    localparam int IO_BIT = 20;

    logic        clk;
    logic        rst;
    logic        read_ce;
    logic [31:0] read_addr;
    logic        write_ce;
    logic [31:0] write_addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy;
    logic [15:0] sw_in;
    logic [15:0] led_out;

    int checks = 0;
    int errors = 0;

    // Expected per-cycle view: {busy, led_out, rdata}.
    logic [48:0] exp_q[$];
    logic [48:0] exp_e;

    // Reference model state.
    logic [31:0] mem_m [1024];
    logic [31:0] held_m;
    logic [31:0] scratch_m;
    logic [31:0] tmr_m;
    logic [15:0] led_m;
    logic        prev_dram_m;
    logic [15:0] sw_seen[$];

    dmem_responder dut (
        .clk       (clk),
        .rst       (rst),
        .read_ce   (read_ce),
        .read_addr (read_addr),
        .write_ce  (write_ce),
        .write_addr(write_addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .busy      (busy),
        .sw_in     (sw_in),
        .led_out   (led_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mmio_val(input logic [3:0] off, input logic [15:0] sw_sync);
        case (off)
            4'h0:    return {16'h0, led_m};
            4'h1:    return {16'h0, sw_sync};
`ifdef DMEM_MMIO_TIMER_EN
            4'h2:    return tmr_m;
`endif
            4'h3:    return scratch_m;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] dram_addr();
        return (32'($urandom) & 32'hFFEF_FC00) | 32'($urandom_range(0, 15));
    endfunction

    function automatic logic [31:0] mmio_addr();
        logic [31:0] off;
        off = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(4, 15)) : 32'($urandom_range(0, 3));
        return (32'($urandom) & 32'hFFEF_FFF0) | 32'h0010_0000 | off;
    endfunction

    task automatic reset_cycle();
        @(posedge clk);
        #1;
        rst        = 1'b1;
        read_ce    = 1'b0;
        read_addr  = '0;
        write_ce   = 1'b0;
        write_addr = '0;
        wdata      = '0;
        sw_in      = '0;
        exp_q.push_back({1'b0, 16'h0, 32'h0});
        held_m      = '0;
        scratch_m   = '0;
        tmr_m       = '0;
        led_m       = '0;
        prev_dram_m = 1'b0;
        sw_seen.delete();
    endtask

    task automatic step(input logic rce, input logic [31:0] raddr, input logic wce,
                        input logic [31:0] waddr, input logic [31:0] wd, input logic [15:0] sw);
        logic [31:0] exp_rd;
        logic [15:0] sw_sync;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        read_ce    = rce;
        read_addr  = raddr;
        write_ce   = wce;
        write_addr = waddr;
        wdata      = wd;
        sw_in      = sw;
        // What the initiator sees during this cycle.
        sw_sync = (sw_seen.size() == 2) ? sw_seen[0] : 16'h0;
        exp_rd  = (rce && raddr[IO_BIT]) ? mmio_val(raddr[3:0], sw_sync) : held_m;
        exp_q.push_back({prev_dram_m, led_m, exp_rd});
        sw_seen.push_back(sw);
        if (sw_seen.size() > 2) void'(sw_seen.pop_front());
        // Effects of the closing edge; writes land before the read (write-first).
        if (wce && !waddr[IO_BIT]) mem_m[waddr[9:0]] = wd;
        else if (wce && waddr[3:0] == 4'h0) led_m = wd[15:0];
        else if (wce && waddr[3:0] == 4'h3) scratch_m = wd;
        if (rce && !raddr[IO_BIT]) held_m = mem_m[raddr[9:0]];
        prev_dram_m = rce && !raddr[IO_BIT];
        tmr_m = tmr_m + 32'd1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_e = exp_q.pop_front();
            checks = checks + 3;
            if (busy !== exp_e[48]) begin
                errors++;
                $display("FAIL busy t=%0t: got %b expected %b", $time, busy, exp_e[48]);
            end
            if (led_out !== exp_e[47:32]) begin
                errors++;
                $display("FAIL led_out t=%0t: got %h expected %h", $time, led_out, exp_e[47:32]);
            end
            if (rdata !== exp_e[31:0]) begin
                errors++;
                $display("FAIL rdata t=%0t: got %h expected %h", $time, rdata, exp_e[31:0]);
            end
        end
    end

    initial begin
        logic        rce;
        logic        wce;
        logic [31:0] ra;
        logic [31:0] wa;
        logic [15:0] sw_cur;

        rst        = 1'b0;
        read_ce    = 1'b0;
        read_addr  = '0;
        write_ce   = 1'b0;
        write_addr = '0;
        wdata      = '0;
        sw_in      = '0;
        reset_cycle();
        reset_cycle();

        for (int i = 0; i < 16; i++) begin
            step(1'b0, 32'h0, 1'b1, 32'(i), $urandom, 16'h0);
        end

        // Basic write then read, busy for one cycle.
        step(1'b0, 32'h0, 1'b1, 32'h0000_0005, 32'hDEAD_BEEF, 16'h0);
        step(1'b1, 32'h0000_0005, 1'b0, 32'h0, 32'h0, 16'h0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 16'h0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 16'h0);
        // Same-edge read/write forwarding.
        step(1'b1, 32'h0000_0007, 1'b1, 32'h0000_0007, 32'h1234_5678, 16'h0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 16'h0);
        // Index wrap.
        step(1'b0, 32'h0, 1'b1, 32'h0000_0405, 32'hAAAA_5555, 16'h0);
        step(1'b1, 32'h0000_0005, 1'b0, 32'h0, 32'h0, 16'h0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 16'h0);
        // LED write and synchronized switches.
        step(1'b0, 32'h0, 1'b1, 32'h0010_0000, 32'h0001_BEEF, 16'h00F0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 16'h00F0);
        step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 16'h00F0);
        step(1'b1, 32'h0010_0001, 1'b0, 32'h0, 32'h0, 16'h00F0);
        // Unmapped offset, timer samples five cycles apart, scratch.
        step(1'b1, 32'h0010_000F, 1'b0, 32'h0, 32'h0, 16'h00F0);
        step(1'b1, 32'h0010_0002, 1'b0, 32'h0, 32'h0, 16'h00F0);
        repeat (4) step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 16'h00F0);
        step(1'b1, 32'h0010_0002, 1'b0, 32'h0, 32'h0, 16'h00F0);
        step(1'b0, 32'h0, 1'b1, 32'h0010_0003, 32'hCAFE_F00D, 16'h00F0);
        step(1'b1, 32'h0010_0003, 1'b0, 32'h0, 32'h0, 16'h00F0);
        // Reset while a DRAM read is outstanding.
        step(1'b1, 32'h0000_0005, 1'b0, 32'h0, 32'h0, 16'h00F0);
        reset_cycle();
        reset_cycle();
        step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 16'h0);
        step(1'b1, 32'h0010_0000, 1'b0, 32'h0, 32'h0, 16'h0);
        step(1'b1, 32'h0000_0405, 1'b0, 32'h0, 32'h0, 16'h0);

        sw_cur = 16'h0;
        for (int i = 0; i < 300; i++) begin
            rce = 1'($urandom_range(0, 1));
            wce = 1'($urandom_range(0, 1));
            ra  = ($urandom_range(0, 2) == 0) ? mmio_addr() : dram_addr();
            wa  = ($urandom_range(0, 2) == 0) ? mmio_addr() : dram_addr();
            if ($urandom_range(0, 3) == 0) sw_cur = 16'($urandom_range(0, 65535));
            step(rce, ra, wce, wa, $urandom, sw_cur);
        end

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
